// File: rtl/instr_encoder.sv
// Rebuilds 32-bit ARM instruction words from the decode stage's internal opcode
// and operand fields, behind a valid/ready stream with an output register and one skid entry.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [3:0]       cond,
  input  logic             en_status,
  input  logic [3:0]       rn,
  input  logic [3:0]       rd,
  input  logic [3:0]       rs,
  input  logic [3:0]       rm,
  input  logic [1:0]       shift_op,
  input  logic [4:0]       imm5,
  input  logic [11:0]      imm12,
  input  logic [23:0]      imm24,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             bad_op,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [3:0] ALU_MOV = 4'b1101;

  logic [3:0]       alu4;
  logic             alu_ok;
  logic [31:0]      enc_word;
  logic             enc_bad;
  logic [31:0]      halt_word;
  logic [11:0]      reg_shift_imm;
  logic [11:0]      reg_shift_reg;

  logic [31:0]      out_word_reg;
  logic             out_valid_reg;
  logic [31:0]      skid_word_reg;
  logic             skid_valid_reg;
  logic             bad_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             accept;
  logic             drain;

  always_comb begin
    alu4   = 4'b0000;
    alu_ok = 1'b1;
    case (opcode[2:0])
      3'b000:  alu4 = 4'b0100;
      3'b001:  alu4 = 4'b0010;
      3'b010:  alu4 = 4'b1010;
      3'b011:  alu4 = 4'b0000;
      3'b100:  alu4 = 4'b1100;
      3'b101:  alu4 = 4'b0001;
      default: alu_ok = 1'b0;
    endcase
  end

  assign halt_word     = {cond, 7'b0001000, 21'b0};
  assign reg_shift_imm = {imm5, shift_op, 1'b0, rm};
  assign reg_shift_reg = {rs, 1'b0, shift_op, 1'b1, rm};

  // Unencodable opcodes fall through to the HALT word and raise enc_bad.
  always_comb begin
    enc_word = halt_word;
    enc_bad  = 1'b0;
    casez (opcode)
      7'b0000000: enc_word = {cond, 3'b001, ALU_MOV, en_status, rn, rd, imm12};
      7'b0000001: enc_word = halt_word;
      7'b0001???: begin
        if (alu_ok) enc_word = {cond, 3'b001, alu4, en_status, rn, rd, imm12};
        else        enc_bad  = 1'b1;
      end
      7'b0010000: enc_word = {cond, 3'b000, ALU_MOV, en_status, rn, rd, reg_shift_imm};
      7'b0011???: begin
        if (alu_ok) enc_word = {cond, 3'b000, alu4, en_status, rn, rd, reg_shift_imm};
        else        enc_bad  = 1'b1;
      end
      7'b0110000: enc_word = {cond, 3'b000, ALU_MOV, en_status, rn, rd, reg_shift_reg};
      7'b0111???: begin
        if (alu_ok) enc_word = {cond, 3'b000, alu4, en_status, rn, rd, reg_shift_reg};
        else        enc_bad  = 1'b1;
      end
      7'b1000???: begin
        // The four branch forms share the LDR-literal opcode space and win over it.
        if (opcode[2:0] == 3'b000)      enc_word = {cond, 4'b1010, imm24};
        else if (opcode[2:0] == 3'b100) enc_word = {cond, 4'b1011, imm24};
        else if (opcode[2:0] == 3'b001) enc_word = {cond, 24'h12FFF1, rm};
        else if (opcode[2:0] == 3'b101) enc_word = {cond, 24'h12FFF3, rm};
        else enc_word = {cond, 3'b010, opcode[2], opcode[1], 1'b0, opcode[0], 1'b1,
                         4'b1111, rd, imm12};
      end
      7'b11?????: begin
        // opcode[3] selects the register-offset form, opcode[4] selects store.
        enc_word = {cond, 2'b01, opcode[3], opcode[2], opcode[1], 1'b0, opcode[0],
                    ~opcode[4], rn, rd, opcode[3] ? reg_shift_imm : imm12};
      end
      default:    enc_bad = 1'b1;
    endcase
  end

  assign in_ready  = ~skid_valid_reg & ~rst;
  assign out_valid = out_valid_reg & ~rst;
  assign out_instr = out_word_reg;
  assign bad_op    = bad_reg;
  assign word_cnt  = cnt_reg;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_word_reg   <= 32'd0;
      out_valid_reg  <= 1'b0;
      skid_word_reg  <= 32'd0;
      skid_valid_reg <= 1'b0;
      bad_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      if (drain || !out_valid_reg) begin
        // A waiting skid word always goes first so ordering is kept.
        if (skid_valid_reg) begin
          out_word_reg   <= skid_word_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_word_reg  <= enc_word;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_word_reg  <= enc_word;
        skid_valid_reg <= 1'b1;
      end
      if (accept && enc_bad) bad_reg <= 1'b1;
      if (drain) cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined instruction encoder: accepts the internal 7-bit opcode plus operand fields, exactly as the CPU's decode stage produces them, and rebuilds the 32-bit ARM word. It is the inverse of the decode stage. It sits between the test/boot program generator and instruction memory, with a valid/ready stream on both sides. It also flags any opcode it cannot encode.

## Interface
- CNT_W, 16, width of the emitted-word counter
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  encoder can accept a beat
- opcode  in  7  internal opcode
- cond  in  4  condition code
- en_status  in  1  S bit
- rn, rd, rs, rm  in  4 each  register fields
- shift_op  in  2  shift type
- imm5  in  5  shift amount
- imm12  in  12  immediate or offset
- imm24  in  24  branch offset
- out_valid  out  1  encoded word present
- out_ready  in  1  sink accepts word
- out_instr  out  32  encoded word
- bad_op  out  1  sticky; set when an unencodable opcode is accepted
- word_cnt  out  CNT_W  words handed off (out_valid&&out_ready), wraps modulo 2^CNT_W

## Operation
- ALU code alu4 from opcode[2:0]: 000→0100 ADD, 001→0010 SUB, 010→1010 CMP, 011→0000 AND, 100→1100 ORR, 101→0001 EOR.
- 0000000 (MOV imm): {cond,001,1101,S,rn,rd,imm12}.
- 0000001 (HALT): {cond,0001000,21'b0}.
- 0001000–0001101 (imm): {cond,001,alu4,S,rn,rd,imm12}.
- 0011000–0011101 (reg): {cond,000,alu4,S,rn,rd,imm5,shift_op,0,rm}. 0010000 is reg MOV with the same layout and alu4=1101.
- 0111000–0111101 (reg-shifted): {cond,000,alu4,S,rn,rd,rs,0,shift_op,1,rm}. 0110000 is RS MOV with the same layout and alu4=1101.
- 1000000 B: {cond,1010,imm24}. 1000100 BL: {cond,1011,imm24}.
- 1000001 BX: {cond,0x12FFF1,rm}. 1000101 BLX: {cond,0x12FFF3,rm}.
- Branch encodings take priority over the load/store form for these 4 opcodes. The other 1000PUW opcodes are LDR literal.
- Load/store, opcode = {k[3:0],P,U,W}:
  - k=1000 LDR lit: {cond,010,P,U,0,W,1,1111,rd,imm12}; rn input ignored.
  - k=1100 LDR imm: {cond,010,P,U,0,W,1,rn,rd,imm12}.
  - k=1101 LDR reg: {cond,011,P,U,0,W,1,rn,rd,imm5,shift_op,0,rm}.
  - k=1110 STR imm / k=1111 STR reg: same as LDR imm / LDR reg with bit20=0.
- Any other opcode:
  - Emit the HALT word with the given cond.
  - Set bad_op, which stays set until rst.
  - The word is still passed downstream and counted.
- Buffering:
  - Output register plus one skid entry.
  - in_ready = skid empty.
  - Accept on in_valid&&in_ready.
  - If the output register is empty or being drained, the encoded beat loads it directly. Otherwise it goes to the skid entry.
  - The skid entry moves to the output register on the next drain.
  - Order is strictly preserved; no beat is dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_instr=0, bad_op=0, word_cnt=0, skid empty. in_ready=1 from the first cycle after rst deasserts.
- While rst=1, in_ready=0 and out_valid=0.
- Latency: a beat accepted in cycle N appears on out_instr with out_valid=1 in cycle N+1.
- Throughput: 1 word/cycle when out_ready=1.
- out_instr and out_valid hold stable while out_valid&&!out_ready.
- in_ready drops in the cycle after the skid fills. It rises in the cycle after the skid drains.
- Simultaneous accept and drain with the skid empty: the new word replaces the output register, and the skid stays empty.
- rst asserted mid-stream discards both the output register and the skid, and clears the counter and bad_op. No partial word is emitted.
- word_cnt increments in the cycle after a handshake. At all-ones it wraps to 0.

## Test plan
- ADD imm, cond=E, S=0, rn=1, rd=2, imm12=0x005 -> out_instr=0xE2812005 one cycle later; word_cnt=1.
- RS SUB, opcode 0111001, S=1, rn=4, rd=5, rs=6, shift_op=01, rm=7 -> 0xE0545637. BX rm=14 -> 0xE12FFF1E.
- Collision and literal cases:
  - opcode 1000000, imm24=0x000010 -> 0xEA000010 (branch, not LDR).
  - opcode 1000110 (LDR lit), rd=3, imm12=0x008, rn=5 -> 0xE59F3008.
- opcode 1010000 with cond=E -> 0xE1000000; bad_op=1 and held through subsequent legal beats.
- Backpressure:
  - Drive 5 back-to-back beats with out_ready=0 -> in_ready=0 after 2 accepts.
  - Release out_ready -> all 5 words emerge in order; word_cnt=5.
- Assert rst with both entries full -> out_valid=0, word_cnt=0, bad_op=0 next cycle. The old words never appear.
